// File: rtl/corefifo_rd_ctrl.sv
// corefifo_rd_ctrl: read-side controller of the CALFIFO asynchronous FIFO.
// Synchronises the Gray write pointer, owns the read pointer, drives the
// 1-cycle-latency RAM read port and presents a first-word-fall-through output.
// Build macro CALFIFO_RD_LEVEL_REG_EN: when defined, rd_count and aempty are
// registered (one cycle later); the FSM always uses the unregistered level.
module corefifo_rd_ctrl #(
  parameter int ADDRWIDTH   = 3,
  parameter int DATAWIDTH   = 18,
  parameter int SYNC_STAGES = 2,
  parameter int AEVAL       = 2
) (
  input  logic                 rclk,
  input  logic                 rreset_n,
  input  logic [ADDRWIDTH:0]   wptr_gray_in,
  output logic [ADDRWIDTH:0]   rptr_gray_out,
  output logic                 mem_re,
  output logic [ADDRWIDTH-1:0] mem_raddr,
  input  logic [DATAWIDTH-1:0] mem_rdata,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic [DATAWIDTH-1:0] rd_data,
  output logic                 empty,
  output logic                 aempty,
  output logic [ADDRWIDTH:0]   rd_count,
  output logic                 underflow
);

  localparam int PW = ADDRWIDTH + 1;
  localparam int SW = ADDRWIDTH + 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_VALID = 2'd2
  } state_e;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 1; i > 0; i--) begin
      b[i-1] = b[i] ^ g[i-1];
    end
    return b;
  endfunction

  logic [PW-1:0]        sync_q [SYNC_STAGES];
  logic [PW-1:0]        rbin_q, rbin_d;
  logic [PW-1:0]        rgray_q, rgray_d;
  logic [PW-1:0]        wbin_s;
  logic [PW-1:0]        level_s;
  logic                 level_nz_s;
  logic                 hs_s;
  logic                 wait_s;
  logic                 mem_re_s;
  logic [SW-1:0]        ae_sum_s;
  logic                 aempty_s;
  state_e               state_q, state_d;
  logic                 rd_valid_q;
  logic [DATAWIDTH-1:0] rd_data_q;
  logic                 underflow_q;

  // Write-pointer synchroniser chain (Gray code, one bit changes per step).
  always_ff @(posedge rclk or negedge rreset_n) begin
    if (!rreset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= wptr_gray_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign wbin_s     = gray2bin(sync_q[SYNC_STAGES-1]);
  assign level_s    = wbin_s - rbin_q;
  assign level_nz_s = |level_s;
  assign hs_s       = rd_valid_q & rd_ready;
  assign wait_s     = (state_q == S_WAIT);

  // Next-state logic: one RAM fetch per IDLE/VALID exit, data lands in WAIT.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (level_nz_s) state_d = S_WAIT;
        else            state_d = S_IDLE;
      end
      S_WAIT: begin
        state_d = S_VALID;
      end
      S_VALID: begin
        if (hs_s) state_d = level_nz_s ? S_WAIT : S_IDLE;
        else      state_d = S_VALID;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // RAM read enable: only ever issued while unread words are present.
  always_comb begin
    mem_re_s = 1'b0;
    case (state_q)
      S_IDLE:  mem_re_s = level_nz_s;
      S_VALID: mem_re_s = hs_s & level_nz_s;
      default: mem_re_s = 1'b0;
    endcase
  end

  assign rbin_d  = rbin_q + {{(PW-1){1'b0}}, mem_re_s};
  assign rgray_d = (rbin_d >> 1) ^ rbin_d;

  // State register and read pointer (binary and Gray move on the same edge).
  always_ff @(posedge rclk or negedge rreset_n) begin
    if (!rreset_n) begin
      state_q <= S_IDLE;
      rbin_q  <= '0;
      rgray_q <= '0;
    end else begin
      state_q <= state_d;
      rbin_q  <= rbin_d;
      rgray_q <= rgray_d;
    end
  end

  // Output word register: capture RAM data in WAIT, drop valid on handshake.
  always_ff @(posedge rclk or negedge rreset_n) begin
    if (!rreset_n) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else if (wait_s) begin
      rd_valid_q <= 1'b1;
      rd_data_q  <= mem_rdata;
    end else if (hs_s) begin
      rd_valid_q <= 1'b0;
    end
  end

  // Underflow flag: consumer asked while nothing was presented.
  always_ff @(posedge rclk or negedge rreset_n) begin
    if (!rreset_n) underflow_q <= 1'b0;
    else           underflow_q <= rd_ready & ~rd_valid_q;
  end

  // Almost-empty counts RAM words plus the held word and any in-flight word.
  assign ae_sum_s = {1'b0, level_s}
                  + {{(SW-1){1'b0}}, rd_valid_q}
                  + {{(SW-1){1'b0}}, wait_s};
  assign aempty_s = (ae_sum_s <= SW'(AEVAL));

`ifdef CALFIFO_RD_LEVEL_REG_EN
  logic [PW-1:0] rd_count_q;
  logic          aempty_q;

  // Retimed level status; lags the live level by one cycle.
  always_ff @(posedge rclk or negedge rreset_n) begin
    if (!rreset_n) begin
      rd_count_q <= '0;
      aempty_q   <= 1'b1;
    end else begin
      rd_count_q <= level_s;
      aempty_q   <= aempty_s;
    end
  end

  assign rd_count = rd_count_q;
  assign aempty   = aempty_q;
`else
  assign rd_count = level_s;
  assign aempty   = aempty_s;
`endif

  assign rptr_gray_out = rgray_q;
  assign mem_re        = mem_re_s;
  assign mem_raddr     = rbin_q[ADDRWIDTH-1:0];
  assign rd_valid      = rd_valid_q;
  assign rd_data       = rd_data_q;
  assign empty         = ~rd_valid_q;
  assign underflow     = underflow_q;

endmodule

// File: doc/corefifo_rd_ctrl.md
Name: corefifo_rd_ctrl

Overview:
Read-side controller for the CALFIFO asynchronous FIFO. It runs entirely in the read clock domain and does the following:
- synchronises the write pointer, which arrives Gray-coded, and converts it to binary internally;
- owns the read pointer in binary and Gray form;
- sequences the 1-cycle-latency RAM read port;
- presents a first-word-fall-through valid/ready output with empty, almost-empty and level status.

It sits between the dual-port RAM and the calibrator's consumer logic.

Parameters:
- ADDRWIDTH, 3: RAM address width. Pointers are ADDRWIDTH+1 bits; depth is 2^ADDRWIDTH.
- DATAWIDTH, 18: RAM/output word width.
- SYNC_STAGES, 2: flop stages on the incoming Gray write pointer, minimum 2.
- AEVAL, 2: almost-empty threshold in words.

Ports:
- rclk  in  1  read clock; all flops are clocked on the rising edge.
- rreset_n  in  1  asynchronous active-low reset.
- wptr_gray_in  in  ADDRWIDTH+1  write pointer, Gray-coded, from the write domain.
- rptr_gray_out  out  ADDRWIDTH+1  registered Gray read pointer, to the write domain.
- mem_re  out  1  RAM read enable.
- mem_raddr  out  ADDRWIDTH  RAM read address, equal to rbin[ADDRWIDTH-1:0].
- mem_rdata  in  DATAWIDTH  RAM data, valid one cycle after mem_re.
- rd_valid  out  1  output word valid.
- rd_ready  in  1  consumer accept.
- rd_data  out  DATAWIDTH  output word.
- empty  out  1  equals !rd_valid.
- aempty  out  1  almost empty.
- rd_count  out  ADDRWIDTH+1  words in RAM not yet fetched.
- underflow  out  1  one-cycle pulse.

Behaviour:
- Reset (async assert, sync release): all flops clear.
  - rptr = 0, rptr_gray_out = 0, sync chain = 0, state = IDLE.
  - rd_valid = 0, rd_data = 0, underflow = 0, mem_re = 0, empty = 1, aempty = 1, rd_count = 0.
  - Reset mid-operation discards any in-flight RAM read.
- Sync and convert:
  - wptr_gray_in passes through SYNC_STAGES flops.
  - The last stage is Gray-to-binary converted combinationally: b[MSB] = g[MSB]; b[i-1] = b[i] ^ g[i-1].
- Level: rd_count = (wbin_sync - rbin) mod 2^(ADDRWIDTH+1). This is combinational from registered values.
- Read pointer:
  - rbin increments by 1 on every cycle with mem_re = 1 and wraps naturally at 2^(ADDRWIDTH+1).
  - rptr_gray_out is registered as (rbin_next >> 1) ^ rbin_next, so it changes on the same edge as rbin.
- State machine:
  - IDLE:
    - rd_count != 0 → mem_re = 1, go to WAIT.
    - Otherwise stay in IDLE.
  - WAIT: mem_rdata is valid. On the edge, rd_data <= mem_rdata and rd_valid <= 1; go to VALID.
  - VALID:
    - Hold rd_data and rd_valid until rd_valid & rd_ready.
    - On handshake with rd_count != 0: mem_re = 1 in the same cycle, rd_valid <= 0, go to WAIT.
    - On handshake with rd_count == 0: rd_valid <= 0, go to IDLE.
- Throughput is at most one word per 2 cycles; this is accepted for calibration traffic.
- mem_re is combinational from state, rd_count and the handshake.
- mem_re is never asserted when rd_count == 0. This guarantees no read of unwritten data.
- Latency: a write pointer change at edge N gives rd_valid high after edge N+SYNC_STAGES+2, starting from IDLE.
- aempty = (rd_count + rd_valid + (state==WAIT)) <= AEVAL, computed at ADDRWIDTH+2 bits so it cannot overflow.
- Underflow: rd_ready = 1 while rd_valid = 0 pulses underflow for one cycle. No pointer or state change results.
- A synchronised level of 2^ADDRWIDTH (full) is legal. A level above that is not generated by a legal writer and is undefined.

Optional Feature:
CALFIFO_RD_LEVEL_REG_EN:
- Defined: rd_count and aempty are registered. They lag by one cycle, improving timing.
  - The FSM still uses the unregistered level, so reads never stall or overrun.
  - aempty clears to 1 on reset.
- Undefined: rd_count and aempty are combinational, as specified above.

Test Plan:
1. Reset: assert rreset_n = 0 mid-transfer.
   - All outputs take the reset values above.
   - rptr_gray_out = 0000.
   - After release with wptr_gray_in = 0000: empty = 1, no mem_re.
2. Single word: wptr_gray_in 0000 → 0001 at edge 0 (SYNC_STAGES = 2).
   - rd_count = 1 and mem_re = 1 after edge 2, with mem_raddr = 0.
   - rd_valid = 1 after edge 4, with rd_data = RAM[0].
   - rptr_gray_out = 0001 after edge 3.
3. Full drain: 8 words, wptr_gray_in = 1100 (binary 8), RAM[i] = i, rd_ready held 1.
   - rd_count = 8 at first sync.
   - 8 handshakes with data 0..7 in order, one every 2 cycles.
   - Ends in IDLE with empty = 1 and rptr_gray_out = 1100.
4. Wrap-around: rptr at binary 15 (Gray 1000), wptr_gray_in = 0000 (binary 0).
   - rd_count = 1, mem_raddr = 7.
   - After the read: rptr_gray_out = 0000, rd_count = 0.
5. Underflow: rd_ready = 1 for 3 cycles with the FIFO empty.
   - underflow high for those 3 cycles.
   - rptr unchanged, no mem_re.
6. Almost-empty (AEVAL = 2): levels 3 → 2 → 1.
   - aempty = 0 / 1 / 1, counting the held word and any in-flight word.
   - Rerun with CALFIFO_RD_LEVEL_REG_EN: identical values, one cycle later.
